mem_axi_access: RTL and testbench
=================================

MEM_AXI_ACCESS -- requirements
Module: mem_axi_access
Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 mem_memory_read  input  1  load request pulse from EX/MEM register.
REQ-004 mem_memory_write  input  1  store request pulse from EX/MEM register.
REQ-005 mem_result  input  32  effective byte address.
REQ-006 mem_op2_selected  input  32  store source data (rs2).
REQ-007 mem_memory_load_type  input  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 none.
REQ-008 mem_memory_store_type  input  2  00 SB, 01 SH, 10 SW, 11 none.
REQ-009 mem_load_data  output  32  aligned, extended load result.
REQ-010 mem_load_valid  output  1  one-cycle pulse: mem_load_data valid.
REQ-011 mem_stall  output  1  freezes the pipeline while an access is pending.
REQ-012 mem_bus_error  output  1  one-cycle pulse: misaligned access or non-OKAY response.
REQ-013 m_axi_awaddr  output  32  write address, word aligned.
REQ-014 m_axi_awvalid  output  1  AW valid.
REQ-015 m_axi_awready  input  1  AW ready.
REQ-016 m_axi_wdata  output  32  write data, lane-replicated.
REQ-017 m_axi_wstrb  output  4  byte strobes.
REQ-018 m_axi_wvalid  output  1  W valid.
REQ-019 m_axi_wready  input  1  W ready.
REQ-020 m_axi_bresp  input  2  write response.
REQ-021 m_axi_bvalid  input  1  B valid.
REQ-022 m_axi_bready  output  1  B ready.
REQ-023 m_axi_araddr  output  32  read address, word aligned.
REQ-024 m_axi_arvalid  output  1  AR valid.
REQ-025 m_axi_arready  input  1  AR ready.
REQ-026 m_axi_rdata  input  32  read data.
REQ-027 m_axi_rresp  input  2  read response.
REQ-028 m_axi_rvalid  input  1  R valid.
REQ-029 m_axi_rready  output  1  R ready.
Function
REQ-030 FSM states: IDLE, WRITE (AW/W outstanding), WRESP, RADDR, RDATA; request is captured (address, data, type) in IDLE because request inputs are single-cycle pulses.
REQ-031 IDLE: valid write -> WRITE with awvalid=wvalid=1 next cycle; else valid read -> RADDR with arvalid=1 next cycle; write wins if both; request with type none is ignored (no stall, no transaction).
REQ-032 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=00): no bus transaction, stay IDLE, mem_bus_error pulses next cycle, no stall.
REQ-033 mem_stall = (state != IDLE) OR (IDLE AND valid aligned request this cycle), combinational.
REQ-034 WRITE: AW and W tracked independently; each valid drops after its handshake; both done -> WRESP with bready=1; bvalid&bready -> IDLE.
REQ-035 RADDR: arvalid&arready -> RDATA with rready=1; rvalid&rready -> IDLE, registering mem_load_data; mem_load_valid pulses the following cycle (stall already low).
REQ-036 awaddr/araddr = {addr[31:2],2'b00}; wstrb SB 0001<<addr[1:0], SH 0011<<{addr[1],0}, SW 1111; wdata SB byte x4, SH half x2, SW word.
REQ-037 Load lane select by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-038 bresp or rresp != 00: transaction completes normally, mem_bus_error pulses with completion, mem_load_data = 0.
REQ-039 Valid signals never deassert before handshake; address/data/strobe stable while valid high.
REQ-040 New requests arriving in non-IDLE states are ignored.
Reset
REQ-041 rst_n low, any state: state IDLE, all AXI valid/ready outputs 0, mem_load_data 0, mem_load_valid/mem_bus_error/mem_stall 0, in-flight access abandoned; interconnect shares rst_n.
Verification
REQ-042 SB addr 0x103, data 0x000000A5, awready/wready same cycle -> awaddr 0x100, wstrb 1000, wdata 0xA5A5A5A5, stall until bvalid.
REQ-043 LB addr 0x102, rdata 0x00800000 -> mem_load_data 0xFFFFFF80; LBU -> 0x00000080; valid pulse 1 cycle after R handshake.
REQ-044 SW with wready 3 cycles after awready -> awvalid drops after AW, wvalid held, single B handshake, stall drops after it.
REQ-045 LW addr 0x102 -> no AR issued, mem_bus_error one pulse, mem_stall 0.
REQ-046 LH addr 0x200 with rresp 10 -> mem_bus_error pulse, mem_load_data 0; rst_n low during RDATA -> rready 0, IDLE next edge.

Source files
------------

// File: rtl/mem_axi_access.sv
// -----------------------------------------------------------------------------
// mem_axi_access
//
// Memory-stage load/store unit for a 32-bit pipeline. It turns single-cycle
// load/store request pulses into AXI4-Lite style transactions on one master
// port, and it stalls the pipeline until the access completes.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_memory_read/write        load/store request pulses (EX/MEM register)
//   mem_result                   effective byte address
//   mem_op2_selected             store source data
//   mem_memory_load_type         000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 none
//   mem_memory_store_type        00 SB, 01 SH, 10 SW, 11 none
//   mem_load_data/_valid         aligned, extended load result and its 1-cycle strobe
//   mem_stall                    holds the pipeline while an access is pending
//   mem_bus_error                1-cycle pulse: misaligned access or non-OKAY response
//   m_axi_aw*/w*/b*              write address, write data, write response channels
//   m_axi_ar*/r*                 read address, read data channels
//
// Requests are captured in IDLE because the request inputs are only valid for
// one cycle. Requests arriving while a transaction is in flight are ignored.
// -----------------------------------------------------------------------------
module mem_axi_access (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        mem_memory_read,
  input  logic        mem_memory_write,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_op2_selected,
  input  logic [2:0]  mem_memory_load_type,
  input  logic [1:0]  mem_memory_store_type,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_stall,
  output logic        mem_bus_error,

  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,

  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,   // AW and/or W still outstanding
    S_WRESP,   // waiting for B
    S_RADDR,   // waiting for AR handshake
    S_RDATA    // waiting for R
  } state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_t      state;

  // Captured read context: byte offset and load type select/extend the lane
  // when R returns, after the request inputs have long gone away.
  logic [1:0]  addr_lo_q;
  logic [2:0]  load_type_q;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic wr_req;
  logic rd_req;
  logic wr_misaligned;
  logic rd_misaligned;
  logic wr_go;
  logic rd_go;
  logic req_error;

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    wr_req        = 1'b0;
    rd_req        = 1'b0;
    wr_misaligned = 1'b0;
    rd_misaligned = 1'b0;

    if (mem_memory_write) begin
      case (mem_memory_store_type)
        ST_SB:   wr_req = 1'b1;
        ST_SH:   begin wr_req = 1'b1; wr_misaligned = mem_result[0];          end
        ST_SW:   begin wr_req = 1'b1; wr_misaligned = |mem_result[1:0];       end
        default: wr_req = 1'b0;
      endcase
    end

    if (mem_memory_read) begin
      case (mem_memory_load_type)
        LD_LB, LD_LBU: rd_req = 1'b1;
        LD_LH, LD_LHU: begin rd_req = 1'b1; rd_misaligned = mem_result[0];    end
        LD_LW:         begin rd_req = 1'b1; rd_misaligned = |mem_result[1:0]; end
        default:       rd_req = 1'b0;
      endcase
    end
  end

  // A valid write takes priority; a read pending alongside it is dropped.
  assign wr_go     = wr_req && !wr_misaligned;
  assign rd_go     = !wr_req && rd_req && !rd_misaligned;
  assign req_error = wr_req ? wr_misaligned : (rd_req && rd_misaligned);

  // Stall is asserted in the very cycle the request is presented so the
  // pipeline does not advance past the access.
  assign mem_stall = (state != S_IDLE) || (wr_go || rd_go);

  // ---------------------------------------------------------------------------
  // Store formatting: replicate the source across lanes, strobe the target
  // ---------------------------------------------------------------------------
  logic [31:0] store_data;
  logic [3:0]  store_strb;

  always_comb begin
    store_data = mem_op2_selected;
    store_strb = 4'b1111;
    case (mem_memory_store_type)
      ST_SB: begin
        store_data = {4{mem_op2_selected[7:0]}};
        store_strb = 4'b0001 << mem_result[1:0];
      end
      ST_SH: begin
        store_data = {2{mem_op2_selected[15:0]}};
        store_strb = 4'b0011 << {mem_result[1], 1'b0};
      end
      default: begin
        store_data = mem_op2_selected;
        store_strb = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  always_comb begin
    lane_byte = m_axi_rdata[7:0];
    case (addr_lo_q)
      2'd0:    lane_byte = m_axi_rdata[7:0];
      2'd1:    lane_byte = m_axi_rdata[15:8];
      2'd2:    lane_byte = m_axi_rdata[23:16];
      default: lane_byte = m_axi_rdata[31:24];
    endcase

    lane_half = addr_lo_q[1] ? m_axi_rdata[31:16] : m_axi_rdata[15:0];

    case (load_type_q)
      LD_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
      LD_LBU:  load_ext = {24'h000000, lane_byte};
      LD_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
      LD_LHU:  load_ext = {16'h0000, lane_half};
      default: load_ext = m_axi_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered AXI and pipeline outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      addr_lo_q      <= 2'b00;
      load_type_q    <= LD_LW;
      m_axi_awaddr   <= 32'h0;
      m_axi_awvalid  <= 1'b0;
      m_axi_wdata    <= 32'h0;
      m_axi_wstrb    <= 4'h0;
      m_axi_wvalid   <= 1'b0;
      m_axi_bready   <= 1'b0;
      m_axi_araddr   <= 32'h0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
      mem_load_data  <= 32'h0;
      mem_load_valid <= 1'b0;
      mem_bus_error  <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses.
      mem_load_valid <= 1'b0;
      mem_bus_error  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (wr_go) begin
            m_axi_awaddr  <= {mem_result[31:2], 2'b00};
            m_axi_wdata   <= store_data;
            m_axi_wstrb   <= store_strb;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= S_WRITE;
          end else if (rd_go) begin
            m_axi_araddr  <= {mem_result[31:2], 2'b00};
            addr_lo_q     <= mem_result[1:0];
            load_type_q   <= mem_memory_load_type;
            m_axi_arvalid <= 1'b1;
            state         <= S_RADDR;
          end else if (req_error) begin
            mem_bus_error <= 1'b1;
          end
        end

        S_WRITE: begin
          // AW and W complete independently; a channel whose valid is already
          // low has finished its handshake on an earlier edge.
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready  <= 1'b0;
            mem_bus_error <= (m_axi_bresp != RESP_OKAY);
            state         <= S_IDLE;
          end
        end

        S_RADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready   <= 1'b0;
            // An error response still completes the load, but with zero data.
            mem_load_data  <= (m_axi_rresp == RESP_OKAY) ? load_ext : 32'h0;
            mem_bus_error  <= (m_axi_rresp != RESP_OKAY);
            mem_load_valid <= 1'b1;
            state          <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_access.sv
// -----------------------------------------------------------------------------
// tb_mem_axi_access
//
// Self-checking bench for mem_axi_access. A negedge-driven AXI slave model with
// programmable per-channel latencies answers the DUT; expected results are
// pushed to a scoreboard queue when a request is issued and popped when the
// DUT completes (B handshake, load_valid, or misalignment error pulse).
// -----------------------------------------------------------------------------
module tb_mem_axi_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_memory_read;
  logic        mem_memory_write;
  logic [31:0] mem_result;
  logic [31:0] mem_op2_selected;
  logic [2:0]  mem_memory_load_type;
  logic [1:0]  mem_memory_store_type;
  logic [31:0] mem_load_data;
  logic        mem_load_valid;
  logic        mem_stall;
  logic        mem_bus_error;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  mem_axi_access dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mem_memory_read       (mem_memory_read),
    .mem_memory_write      (mem_memory_write),
    .mem_result            (mem_result),
    .mem_op2_selected      (mem_op2_selected),
    .mem_memory_load_type  (mem_memory_load_type),
    .mem_memory_store_type (mem_memory_store_type),
    .mem_load_data         (mem_load_data),
    .mem_load_valid        (mem_load_valid),
    .mem_stall             (mem_stall),
    .mem_bus_error         (mem_bus_error),
    .m_axi_awaddr          (m_axi_awaddr),
    .m_axi_awvalid         (m_axi_awvalid),
    .m_axi_awready         (m_axi_awready),
    .m_axi_wdata           (m_axi_wdata),
    .m_axi_wstrb           (m_axi_wstrb),
    .m_axi_wvalid          (m_axi_wvalid),
    .m_axi_wready          (m_axi_wready),
    .m_axi_bresp           (m_axi_bresp),
    .m_axi_bvalid          (m_axi_bvalid),
    .m_axi_bready          (m_axi_bready),
    .m_axi_araddr          (m_axi_araddr),
    .m_axi_arvalid         (m_axi_arvalid),
    .m_axi_arready         (m_axi_arready),
    .m_axi_rdata           (m_axi_rdata),
    .m_axi_rresp           (m_axi_rresp),
    .m_axi_rvalid          (m_axi_rvalid),
    .m_axi_rready          (m_axi_rready)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {K_WRITE, K_LOAD, K_ERR} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
  endtask

  // Reference formatting, written from the lane tables rather than the RTL.
  function automatic logic [3:0] ref_strb(input logic [1:0] st, input logic [1:0] a);
    case (st)
      2'b00:   case (a) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                        2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] st, input logic [31:0] d);
    case (st)
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (lt)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b011:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // AXI slave model and completion monitor (single negedge process, so the
  // readies it drives and the handshakes it predicts never race)
  // ---------------------------------------------------------------------------
  int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, ar_got, b_fire, r_fire;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  int          aw_hs = 0;
  int          ar_hs = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
    end else begin
      // --- completions of handshakes made on the previous rising edge ---
      if (b_fire) begin
        b_fire = 1'b0;
        m_axi_bvalid = 1'b0;
        if (sb.size() == 0) check("wr_unexpected", 32'(sb.size()), 32'd1);
        else begin
          mon_e = sb.pop_front();
          check("wr_kind",   32'(mon_e.kind == K_WRITE), 32'd1);
          check("wr_awaddr", cap_awaddr, mon_e.addr);
          check("wr_wdata",  cap_wdata, mon_e.data);
          check("wr_wstrb",  32'(cap_wstrb), 32'(mon_e.strb));
          check("wr_err",    32'(mem_bus_error), 32'(mon_e.err));
          check("wr_lvalid", 32'(mem_load_valid), 32'd0);
        end
      end else if (r_fire) begin
        r_fire = 1'b0;
        m_axi_rvalid = 1'b0;
        check("ld_valid", 32'(mem_load_valid), 32'd1);
        check("ld_stall", 32'(mem_stall), 32'd0);
        if (sb.size() == 0) check("ld_unexpected", 32'(sb.size()), 32'd1);
        else begin
          mon_e = sb.pop_front();
          check("ld_kind",   32'(mon_e.kind == K_LOAD), 32'd1);
          check("ld_araddr", cap_araddr, mon_e.addr);
          check("ld_data",   mem_load_data, mon_e.data);
          check("ld_err",    32'(mem_bus_error), 32'(mon_e.err));
        end
      end else if (mem_load_valid) begin
        check("stray_lvalid", 32'(mem_load_valid), 32'd0);
      end else if (mem_bus_error) begin
        if (sb.size() == 0) check("stray_err", 32'(mem_bus_error), 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("mis_kind", 32'(mon_e.kind == K_ERR), 32'd1);
        end
      end

      // --- one channel done, the other pending: finished valid must be low ---
      if (aw_got && !w_got) begin
        check("aw_dropped", 32'(m_axi_awvalid), 32'd0);
        check("w_held",     32'(m_axi_wvalid), 32'd1);
      end
      if (w_got && !aw_got) begin
        check("w_dropped", 32'(m_axi_wvalid), 32'd0);
        check("aw_held",   32'(m_axi_awvalid), 32'd1);
      end

      // --- B: offered only after both AW and W handshakes have happened ---
      if (aw_got && w_got && !m_axi_bvalid) begin
        if (b_cnt >= b_lat) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = cfg_bresp; b_cnt = 0;
        end else b_cnt++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        check("b_stall", 32'(mem_stall), 32'd1);
        b_fire = 1'b1; aw_got = 1'b0; w_got = 1'b0;
      end

      // --- AW / W ---
      if (m_axi_awvalid && !aw_got) begin
        if (aw_cnt >= aw_lat) begin
          m_axi_awready = 1'b1; aw_got = 1'b1; cap_awaddr = m_axi_awaddr; aw_hs++; aw_cnt = 0;
        end else begin
          m_axi_awready = 1'b0; aw_cnt++;
        end
      end else m_axi_awready = 1'b0;

      if (m_axi_wvalid && !w_got) begin
        if (w_cnt >= w_lat) begin
          m_axi_wready = 1'b1; w_got = 1'b1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; w_cnt = 0;
        end else begin
          m_axi_wready = 1'b0; w_cnt++;
        end
      end else m_axi_wready = 1'b0;

      // --- R: offered only after the AR handshake ---
      if (ar_got && !m_axi_rvalid) begin
        if (r_cnt >= r_lat) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp; r_cnt = 0;
        end else r_cnt++;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_fire = 1'b1; ar_got = 1'b0;
      end

      // --- AR ---
      if (m_axi_arvalid && !ar_got) begin
        if (ar_cnt >= ar_lat) begin
          m_axi_arready = 1'b1; ar_got = 1'b1; cap_araddr = m_axi_araddr; ar_hs++; ar_cnt = 0;
        end else begin
          m_axi_arready = 1'b0; ar_cnt++;
        end
      end else m_axi_arready = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] lt, input logic [1:0] st, input logic exp_stall);
    @(posedge clk); #1;
    mem_memory_read       = rd;
    mem_memory_write      = wr;
    mem_result            = a;
    mem_op2_selected      = d;
    mem_memory_load_type  = lt;
    mem_memory_store_type = st;
    #1 check("req_stall", 32'(mem_stall), 32'(exp_stall));
    @(posedge clk); #1;
    mem_memory_read       = 1'b0;
    mem_memory_write      = 1'b0;
    mem_memory_load_type  = 3'b111;
    mem_memory_store_type = 2'b11;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    #1 check("idle_stall", 32'(mem_stall), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st,
                          input int awl, input int wl, input logic [1:0] br, input logic also_rd);
    exp_t e;
    int   ar0;
    logic mis;
    aw_lat = awl; w_lat = wl; b_lat = 1; cfg_bresp = br;
    mis    = (st == 2'b01 && a[0]) || (st == 2'b10 && a[1:0] != 2'b00);
    e.kind = mis ? K_ERR : K_WRITE;
    e.addr = {a[31:2], 2'b00};
    e.data = ref_wdata(st, d);
    e.strb = ref_strb(st, a[1:0]);
    e.err  = mis || (br != 2'b00);
    ar0    = ar_hs;
    sb.push_back(e);
    issue(also_rd, 1'b1, a, d, 3'b010, st, !mis);
    wait_done("st_done");
    check("st_no_ar", 32'(ar_hs - ar0), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] lt, input logic [31:0] w,
                         input logic [1:0] rr, input int arl, input int rl);
    exp_t e;
    int   ar0;
    logic mis;
    ar_lat = arl; r_lat = rl; cfg_rdata = w; cfg_rresp = rr;
    mis    = ((lt == 3'b001 || lt == 3'b100) && a[0]) || (lt == 3'b010 && a[1:0] != 2'b00);
    e.kind = mis ? K_ERR : K_LOAD;
    e.addr = {a[31:2], 2'b00};
    e.data = (rr == 2'b00) ? ref_load(lt, a[1:0], w) : 32'h0;
    e.strb = 4'h0;
    e.err  = mis || (rr != 2'b00);
    ar0    = ar_hs;
    sb.push_back(e);
    issue(1'b1, 1'b0, a, 32'h0, lt, 2'b11, !mis);
    wait_done("ld_done");
    check("ld_ar_count", 32'(ar_hs - ar0), mis ? 32'd0 : 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ar0, aw0, n;
    exp_t e;

    rst_n = 1'b0;
    mem_memory_read = 1'b0; mem_memory_write = 1'b0;
    mem_result = 32'h0; mem_op2_selected = 32'h0;
    mem_memory_load_type = 3'b111; mem_memory_store_type = 2'b11;
    m_axi_bresp = 2'b00; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
    aw_lat = 0; w_lat = 0; b_lat = 1; ar_lat = 0; r_lat = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid",  32'(m_axi_wvalid), 32'd0);
    check("rst_bready",  32'(m_axi_bready), 32'd0);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_rready",  32'(m_axi_rready), 32'd0);
    check("rst_ldata",   mem_load_data, 32'h0);
    check("rst_lvalid",  32'(mem_load_valid), 32'd0);
    check("rst_err",     32'(mem_bus_error), 32'd0);
    check("rst_stall",   32'(mem_stall), 32'd0);
    rst_n = 1'b1;

    // Stores: byte/half/word, both channel orderings, error response
    do_store(32'h0000_0103, 32'h0000_00A5, 2'b00, 0, 0, 2'b00, 1'b0);
    check("sb_awaddr_const", cap_awaddr, 32'h0000_0100);
    check("sb_wdata_const",  cap_wdata,  32'hA5A5_A5A5);
    check("sb_wstrb_const",  32'(cap_wstrb), 32'h8);
    do_store(32'h0000_0102, 32'h1234_BEEF, 2'b01, 2, 0, 2'b00, 1'b0);
    do_store(32'h0000_0200, 32'hDEAD_BEEF, 2'b10, 0, 3, 2'b00, 1'b0);
    do_store(32'h0000_0301, 32'h0000_003C, 2'b00, 1, 1, 2'b10, 1'b0);

    // Loads: lane select, sign/zero extension, latencies, error response
    do_load(32'h0000_0102, 3'b000, 32'h0080_0000, 2'b00, 0, 0);
    check("lb_const", mem_load_data, 32'hFFFF_FF80);
    do_load(32'h0000_0102, 3'b011, 32'h0080_0000, 2'b00, 0, 0);
    check("lbu_const", mem_load_data, 32'h0000_0080);
    do_load(32'h0000_0202, 3'b001, 32'h8001_1234, 2'b00, 1, 0);
    do_load(32'h0000_0200, 3'b100, 32'h1111_F00D, 2'b00, 0, 2);
    do_load(32'h0000_0304, 3'b010, 32'hCAFE_F00D, 2'b00, 2, 3);
    do_load(32'h0000_0200, 3'b001, 32'h7777_7777, 2'b10, 0, 1);
    check("lh_err_const", mem_load_data, 32'h0);

    // Misaligned: no transaction, one error pulse, no stall
    do_load (32'h0000_0102, 3'b010, 32'h0, 2'b00, 0, 0);
    do_load (32'h0000_0103, 3'b100, 32'h0, 2'b00, 0, 0);
    aw0 = aw_hs;
    do_store(32'h0000_0101, 32'h0, 2'b01, 0, 0, 2'b00, 1'b0);
    do_store(32'h0000_0202, 32'h0, 2'b10, 0, 0, 2'b00, 1'b0);
    check("mis_no_aw", 32'(aw_hs - aw0), 32'd0);

    // Type "none" requests are ignored entirely
    ar0 = ar_hs; aw0 = aw_hs;
    issue(1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b111, 2'b11, 1'b0);
    issue(1'b0, 1'b1, 32'h0000_0400, 32'h1, 3'b111, 2'b11, 1'b0);
    repeat (4) @(posedge clk);
    check("none_no_ar", 32'(ar_hs - ar0), 32'd0);
    check("none_no_aw", 32'(aw_hs - aw0), 32'd0);

    // Simultaneous read and write: write wins, read dropped
    do_store(32'h0000_0500, 32'h0BAD_CAFE, 2'b10, 0, 0, 2'b00, 1'b1);

    // Read request arriving while a store is in flight is ignored
    ar0 = ar_hs;
    aw_lat = 0; w_lat = 5; b_lat = 1; cfg_bresp = 2'b00;
    e.kind = K_WRITE; e.addr = 32'h0000_0600; e.data = 32'h0102_0304; e.strb = 4'hF; e.err = 1'b0;
    sb.push_back(e);
    issue(1'b0, 1'b1, 32'h0000_0600, 32'h0102_0304, 3'b111, 2'b10, 1'b1);
    issue(1'b1, 1'b0, 32'h0000_0700, 32'h0, 3'b010, 2'b11, 1'b1);
    wait_done("busy_done");
    repeat (3) @(posedge clk);
    check("busy_no_ar", 32'(ar_hs - ar0), 32'd0);

    // Reset while waiting in RDATA abandons the access
    ar_lat = 0; r_lat = 50; cfg_rdata = 32'h0; cfg_rresp = 2'b00;
    issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b001, 2'b11, 1'b1);
    n = 0;
    while (!m_axi_rready && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1 check("rdata_reached", 32'(m_axi_rready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rready", 32'(m_axi_rready), 32'd0);
    check("rst_mid_stall",  32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_mid_lvalid",  32'(mem_load_valid), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Recovery after reset
    do_load(32'h0000_0800, 3'b010, 32'h89AB_CDEF, 2'b00, 0, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
